seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, handshaked execute-stage ALU for the Y86 core. Computes `valE = aluB op aluA` for add/sub/and/xor as before, and adds iterative signed multiply and three shift modes. It owns the architectural condition-code register (ZSO) instead of producing flags combinationally. It sits between decode and memory stages with valid/ready on both sides, so multi-cycle ops stall upstream cleanly.

## Interface
- `W`, 32: datapath width. Power of two, ≥ 8.
- `MUL_EN`, 1: 1 enables op 4 (mul). 0 makes op 4 illegal.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: operands/op valid.
- `in_ready` out 1: unit accepts this cycle.
- `aluA` in W: operand A (subtrahend / shift amount).
- `aluB` in W: operand B.
- `aluOP` in 4: operation code.
- `set_cc` in 1: update ZSO when this op's result is produced.
- `out_valid` out 1: `valE`/`out_err` valid.
- `out_ready` in 1: downstream consumes result.
- `valE` out W: result.
- `out_err` out 1: illegal op flag for the current result.
- `ZSO` out 3: registered CC. [2]=Z, [1]=S, [0]=O.

## Operation
- Ops: 0 add (B+A); 1 sub (B−A); 2 and; 3 xor; 4 mul (low W bits of signed B×A); 5 shl (B<<sh); 6 shr logical; 7 sar arithmetic. `sh = aluA[$clog2(W)-1:0]`; upper bits are ignored.
- Ops 8–15 (and 4 when `MUL_EN=0`) are illegal: `valE=0`, `out_err=1`, ZSO never updated.
- Overflow flag O:
  - add: operands same sign, result sign differs.
  - sub: signs of B and A differ, result sign ≠ sign of B.
  - mul: full 2W-bit signed product ≠ sign-extension of its low W bits.
  - Logic and shift ops: O=0.
- Z = (valE==0). S = valE[W−1].
- ZSO loads on the same edge `valE` is loaded, only if `set_cc` was high at accept. Otherwise ZSO holds.
- FSM:
  - IDLE: `in_ready = !out_valid || out_ready`. Accepting a non-mul op loads the output register and stays in IDLE. Accepting mul latches operand magnitudes and signs, clears count, and goes to MUL.
  - MUL: `in_ready=0`. One shift-add step per cycle, W steps. Then go to FIX.
  - FIX: conditionally negate, compute O, load output/ZSO, return to IDLE.
- Output register: loaded results hold stable while `out_valid && !out_ready`. `out_valid` drops on the consume edge unless a new result loads on that same edge.
- Reset values: state IDLE, `out_valid=0`, `valE=0`, `out_err=0`, `ZSO=3'b100`, count 0.

## Timing
- Accepting edge = edge 0.
- Non-mul ops: `out_valid` is high after edge 1, i.e. the result is visible in the cycle following acceptance. Throughput is 1 op/cycle when `out_ready` stays high.
- mul: `in_ready` is low from edge 1 through edge W+1. `out_valid` rises after edge W+2 (W iteration edges + FIX).
- Accept and drain in the same cycle is legal. The new result replaces the old one with no bubble.
- Back-pressure: `in_ready` is low whenever `out_valid && !out_ready`. No input is lost.
- Reset mid-mul aborts the operation: no result, no CC update, and `in_ready=1` in the first cycle after reset deasserts.
- Inputs are sampled only on the accepting edge. Changes while in MUL/FIX are ignored.

## Structure
- Shared package `y86_alu_pkg`: op encoding constants (`ALU_ADD`…`ALU_SAR`), ZSO bit indices (`CC_Z`, `CC_S`, `CC_O`), FSM state enum, CC reset value.
- Sub-module `mul_iter`: W-cycle unsigned shift-add core with start/done.
  - Top handles sign handling, FIX, the output register, ZSO and the FSM.
  - Single-cycle ops are combinational into the output register.

## Test plan
- W=32, add `aluB=0x7FFFFFFF`, `aluA=1`, `set_cc=1`. Expect `valE=0x80000000`, `ZSO=3'b011`, `out_valid` after edge 1. Follow with `xor 5^5`, `set_cc=0`. Expect `valE=0`, ZSO unchanged at `3'b011`.
- sub `aluB=5`, `aluA=5`, `set_cc=1`. Expect `valE=0`, `ZSO=3'b100`. Then sub `aluB=0x80000000`, `aluA=1`. Expect `valE=0x7FFFFFFF`, `ZSO=3'b001`.
- mul `aluB=-3`, `aluA=7`, `set_cc=1`. Expect `in_ready` low for 33 cycles, `out_valid` after edge 34, `valE=0xFFFFFFEB`, `ZSO=3'b010`. Then mul `0x10000×0x10000`. Expect `valE=0`, `ZSO=3'b101`.
- Shifts with `aluB=0x80000000`, `aluA=0x3F` (sh=31):
  - sar: expect `0xFFFFFFFF`.
  - shr: expect `0x00000001`.
  - shl with `aluB=1`: expect `0x80000000`.
  - O=0 in all cases.
- Hold `out_ready=0` for 5 cycles after an add. Expect `valE` stable and `in_ready=0`. Raise `out_ready` with a new op pending. Expect accept on the drain edge and the new result next cycle.
- Assert `reset` 10 cycles into a mul. Expect `out_valid=0`, `ZSO=3'b100`, `in_ready=1` after reset deasserts. Op `0xA` gives `out_err=1`, `valE=0`, ZSO unchanged. With `MUL_EN=0`, op 4 gives `out_err=1`.

Source files
------------

// File: rtl/y86_alu_pkg.sv
// Shared definitions for the Y86 execute-stage ALU: op codes, CC bit layout,
// sequencer states and the CC reset value.
package y86_alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_XOR = 4'd3;
    localparam logic [3:0] ALU_MUL = 4'd4;
    localparam logic [3:0] ALU_SHL = 4'd5;
    localparam logic [3:0] ALU_SHR = 4'd6;
    localparam logic [3:0] ALU_SAR = 4'd7;

    localparam int unsigned CC_Z = 2;
    localparam int unsigned CC_S = 1;
    localparam int unsigned CC_O = 0;

    localparam logic [2:0] CC_RESET = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_FIX
    } alu_state_t;

endpackage

// File: rtl/seq_alu_if.sv
// Decode-to-memory handshake bundle for the execute-stage ALU.
interface seq_alu_if #(
    parameter int unsigned W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] aluA;
    logic [W-1:0] aluB;
    logic [3:0]   aluOP;
    logic         set_cc;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] valE;
    logic         out_err;

    modport master (
        output in_valid, aluA, aluB, aluOP, set_cc, out_ready,
        input  in_ready, out_valid, valE, out_err
    );

    modport slave (
        input  in_valid, aluA, aluB, aluOP, set_cc, out_ready,
        output in_ready, out_valid, valE, out_err
    );
endinterface

// File: rtl/seq_alu_mul_iter.sv
// Unsigned W-step shift-add multiplier; one partial product per cycle,
// done stays high until the next start.
module mul_iter #(
    parameter int unsigned W = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [W-1:0]   mcand,
    input  logic [W-1:0]   mplier,
    output logic           done,
    output logic [2*W-1:0] product
);
    localparam int unsigned CW = $clog2(W);

    logic [W-1:0]  mc_q;
    logic [W-1:0]  hi_q;
    logic [W-1:0]  lo_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic [W:0]    sum;

    // Partial sum of the current step; carry lands in the shifted-in bit
    always_comb begin
        sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mc_q} : '0);
    end

    // Load on start, then shift the {hi,lo} product right once per step
    always_ff @(posedge clk) begin
        if (reset) begin
            mc_q   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done   <= 1'b0;
        end else if (start) begin
            mc_q   <= mcand;
            hi_q   <= '0;
            lo_q   <= mplier;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            done   <= 1'b0;
        end else if (busy_q) begin
            hi_q  <= sum[W:1];
            lo_q  <= {sum[0], lo_q[W-1:1]};
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(W - 1)) begin
                busy_q <= 1'b0;
                done   <= 1'b1;
            end
        end
    end

    assign product = {hi_q, lo_q};
endmodule

// File: rtl/seq_alu.sv
// Execute-stage ALU with valid/ready on both sides, iterative signed multiply
// and an owned ZSO condition-code register.
module seq_alu
    import y86_alu_pkg::*;
#(
    parameter int unsigned W      = 32,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    seq_alu_if.slave     bus,
    output logic [2:0]   ZSO
);
    localparam int unsigned SHW = $clog2(W);

    alu_state_t     state_q, state_d;
    logic           in_ready;
    logic           accept;
    logic           op_is_mul;
    logic           mul_start;
    logic           load_single;
    logic           load_fix;

    logic [W-1:0]   val_q;
    logic           err_q;
    logic           ov_q;
    logic           neg_q;
    logic           setcc_q;

    logic [W-1:0]   res;
    logic           res_o;
    logic           res_err;
    logic [SHW-1:0] sh;
    logic [W-1:0]   mag_a, mag_b;

    logic           mul_done;
    logic [2*W-1:0] product;
    logic [2*W-1:0] prod_s;
    logic           prod_o;

    function automatic logic [2:0] flags_of(input logic [W-1:0] v, input logic o);
        logic [2:0] f;
        f       = '0;
        f[CC_Z] = (v == '0);
        f[CC_S] = v[W-1];
        f[CC_O] = o;
        return f;
    endfunction

    assign op_is_mul = MUL_EN && (bus.aluOP == ALU_MUL);
    assign sh        = bus.aluA[SHW-1:0];
    assign mag_a     = bus.aluA[W-1] ? ('0 - bus.aluA) : bus.aluA;
    assign mag_b     = bus.aluB[W-1] ? ('0 - bus.aluB) : bus.aluB;

    mul_iter #(.W(W)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .mcand   (mag_b),
        .mplier  (mag_a),
        .done    (mul_done),
        .product (product)
    );

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state: mul detours through MUL and FIX, everything else stays IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept && op_is_mul) state_d = ST_MUL;
            ST_MUL:  if (mul_done)            state_d = ST_FIX;
            ST_FIX:                           state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    // Handshake and load strobes derived from the current state
    always_comb begin
        in_ready    = (state_q == ST_IDLE) && (!bus.out_valid || bus.out_ready);
        accept      = in_ready && bus.in_valid;
        mul_start   = accept && op_is_mul;
        load_single = accept && !op_is_mul;
        load_fix    = (state_q == ST_FIX);
    end

    // Single-cycle result, overflow and legality for the presented op
    always_comb begin
        res     = '0;
        res_o   = 1'b0;
        res_err = 1'b0;
        case (bus.aluOP)
            ALU_ADD: begin
                res   = bus.aluB + bus.aluA;
                res_o = (bus.aluB[W-1] == bus.aluA[W-1]) && (res[W-1] != bus.aluB[W-1]);
            end
            ALU_SUB: begin
                res   = bus.aluB - bus.aluA;
                res_o = (bus.aluB[W-1] != bus.aluA[W-1]) && (res[W-1] != bus.aluB[W-1]);
            end
            ALU_AND: res = bus.aluB & bus.aluA;
            ALU_XOR: res = bus.aluB ^ bus.aluA;
            ALU_SHL: res = bus.aluB << sh;
            ALU_SHR: res = bus.aluB >> sh;
            ALU_SAR: res = $signed(bus.aluB) >>> sh;
            default: res_err = 1'b1;
        endcase
    end

    // Sign fix-up of the unsigned product and its overflow
    always_comb begin
        prod_s = neg_q ? ('0 - product) : product;
        prod_o = (prod_s[2*W-1:W] != {W{prod_s[W-1]}});
    end

    // Output register, CC register and the operand context of a pending mul
    always_ff @(posedge clk) begin
        if (reset) begin
            val_q       <= '0;
            err_q       <= 1'b0;
            ov_q        <= 1'b0;
            ZSO         <= CC_RESET;
            neg_q       <= 1'b0;
            setcc_q     <= 1'b0;
        end else begin
            if (load_single) begin
                val_q <= res;
                err_q <= res_err;
                ov_q  <= 1'b1;
                if (bus.set_cc && !res_err) ZSO <= flags_of(res, res_o);
            end else if (load_fix) begin
                val_q <= prod_s[W-1:0];
                err_q <= 1'b0;
                ov_q  <= 1'b1;
                if (setcc_q) ZSO <= flags_of(prod_s[W-1:0], prod_o);
            end else if (ov_q && bus.out_ready) begin
                ov_q <= 1'b0;
            end
            if (mul_start) begin
                neg_q   <= bus.aluA[W-1] ^ bus.aluB[W-1];
                setcc_q <= bus.set_cc;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = ov_q;
    assign bus.valE      = val_q;
    assign bus.out_err   = err_q;
endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (W=32, plus a MUL_EN=0 instance).
module tb_seq_alu;
    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] zso, zso0;
    int         checks = 0;
    int         failures = 0;
    int         rise_edge;
    int         low_cnt;
    bit         stable;

    always #5 clk = ~clk;

    seq_alu_if #(.W(32)) bus ();
    seq_alu_if #(.W(32)) bus0 ();

    seq_alu #(.W(32), .MUL_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .ZSO   (zso)
    );

    seq_alu #(.W(32), .MUL_EN(1'b0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0),
        .ZSO   (zso0)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic cc);
        bus.aluOP    = op;
        bus.aluA     = a;
        bus.aluB     = b;
        bus.set_cc   = cc;
        bus.in_valid = 1'b1;
        check("accept_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result();
        rise_edge = 0;
        low_cnt   = 0;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (bus.out_valid) begin
                rise_edge = e;
                break;
            end
            if (!bus.in_ready) low_cnt++;
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.aluA      = '0;
        bus.aluB      = '0;
        bus.aluOP     = '0;
        bus.set_cc    = 1'b0;
        bus.out_ready = 1'b1;
        bus0.in_valid = 1'b0;
        bus0.aluA     = '0;
        bus0.aluB     = '0;
        bus0.aluOP    = '0;
        bus0.set_cc   = 1'b0;
        bus0.out_ready = 1'b1;
        tick(); tick(); tick();
        reset = 1'b0;

        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_valE",      64'(bus.valE),      64'd0);
        check("rst_out_err",   64'(bus.out_err),   64'd0);
        check("rst_zso",       64'(zso),           64'b100);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);

        // add overflow into sign bit
        accept(4'd0, 32'd1, 32'h7FFF_FFFF, 1'b1);
        check("add_valid", 64'(bus.out_valid), 64'd1);
        check("add_valE",  64'(bus.valE),      64'h8000_0000);
        check("add_zso",   64'(zso),           64'b011);

        // back-to-back xor without CC update
        accept(4'd3, 32'd5, 32'd5, 1'b0);
        check("xor_valE", 64'(bus.valE), 64'd0);
        check("xor_zso",  64'(zso),      64'b011);

        accept(4'd1, 32'd5, 32'd5, 1'b1);
        check("sub0_valE", 64'(bus.valE), 64'd0);
        check("sub0_zso",  64'(zso),      64'b100);

        accept(4'd1, 32'd1, 32'h8000_0000, 1'b1);
        check("subov_valE", 64'(bus.valE), 64'h7FFF_FFFF);
        check("subov_zso",  64'(zso),      64'b001);

        accept(4'd2, 32'h0000_0FF0, 32'h0000_F0F0, 1'b1);
        check("and_valE", 64'(bus.valE), 64'h0000_00F0);
        check("and_zso",  64'(zso),      64'b000);

        // shifts by 31 with upper shift-amount bits set
        accept(4'd7, 32'h3F, 32'h8000_0000, 1'b1);
        check("sar_valE", 64'(bus.valE), 64'hFFFF_FFFF);
        check("sar_zso",  64'(zso),      64'b010);
        accept(4'd6, 32'h3F, 32'h8000_0000, 1'b1);
        check("shr_valE", 64'(bus.valE), 64'h0000_0001);
        check("shr_zso",  64'(zso),      64'b000);
        accept(4'd5, 32'h3F, 32'h0000_0001, 1'b1);
        check("shl_valE", 64'(bus.valE), 64'h8000_0000);
        check("shl_zso",  64'(zso),      64'b010);

        // signed mul -3 * 7; operands scrambled after accept must not matter
        accept(4'd4, 32'd7, 32'hFFFF_FFFD, 1'b1);
        check("mul_busy", 64'(bus.in_ready), 64'd0);
        bus.aluA   = 32'h1234_5678;
        bus.aluB   = 32'h0BAD_F00D;
        bus.set_cc = 1'b0;
        wait_result();
        check("mul_rise_edge", 64'(rise_edge), 64'd34);
        check("mul_low_cnt",   64'(low_cnt),   64'd33);
        check("mul_valE",      64'(bus.valE),  64'hFFFF_FFEB);
        check("mul_zso",       64'(zso),       64'b010);
        check("mul_ready_back", 64'(bus.in_ready), 64'd1);

        accept(4'd4, 32'h0001_0000, 32'h0001_0000, 1'b1);
        wait_result();
        check("mulov_rise_edge", 64'(rise_edge), 64'd34);
        check("mulov_valE",      64'(bus.valE),  64'd0);
        check("mulov_zso",       64'(zso),       64'b101);

        // back-pressure: result held, new op waits for the drain edge
        accept(4'd0, 32'd3, 32'd2, 1'b0);
        check("bp_valE", 64'(bus.valE), 64'd5);
        bus.out_ready = 1'b0;
        bus.aluOP     = 4'd0;
        bus.aluA      = 32'd20;
        bus.aluB      = 32'd10;
        bus.in_valid  = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.in_ready !== 1'b0 || bus.valE !== 32'd5 || bus.out_valid !== 1'b1)
                stable = 1'b0;
        end
        check("bp_stable", 64'(stable), 64'd1);
        bus.out_ready = 1'b1;
        #1;
        check("bp_drain_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        check("bp_new_valid", 64'(bus.out_valid), 64'd1);
        check("bp_new_valE",  64'(bus.valE),      64'd30);
        tick();
        check("bp_drained", 64'(bus.out_valid), 64'd0);

        // reset 10 cycles into a mul aborts it
        accept(4'd4, 32'd3, 32'd3, 1'b1);
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rmul_out_valid", 64'(bus.out_valid), 64'd0);
        check("rmul_zso",       64'(zso),           64'b100);
        check("rmul_in_ready",  64'(bus.in_ready),  64'd1);
        stable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.out_valid !== 1'b0) stable = 1'b0;
        end
        check("rmul_no_result", 64'(stable), 64'd1);

        // illegal op leaves CC alone
        accept(4'd0, 32'd1, 32'h7FFF_FFFF, 1'b1);
        check("pre_ill_zso", 64'(zso), 64'b011);
        accept(4'hA, 32'd9, 32'd9, 1'b1);
        check("ill_err",  64'(bus.out_err), 64'd1);
        check("ill_valE", 64'(bus.valE),    64'd0);
        check("ill_zso",  64'(zso),         64'b011);
        accept(4'd0, 32'd1, 32'd1, 1'b0);
        check("post_ill_err",  64'(bus.out_err), 64'd0);
        check("post_ill_valE", 64'(bus.valE),    64'd2);

        // MUL_EN=0: op 4 is illegal and single-cycle
        bus0.aluOP    = 4'd0;
        bus0.aluA     = 32'd1;
        bus0.aluB     = 32'h7FFF_FFFF;
        bus0.set_cc   = 1'b1;
        bus0.in_valid = 1'b1;
        tick();
        check("nomul_pre_zso", 64'(zso0), 64'b011);
        bus0.aluOP = 4'd4;
        bus0.aluA  = 32'd7;
        bus0.aluB  = 32'd3;
        tick();
        bus0.in_valid = 1'b0;
        check("nomul_valid", 64'(bus0.out_valid), 64'd1);
        check("nomul_err",   64'(bus0.out_err),   64'd1);
        check("nomul_valE",  64'(bus0.valE),      64'd0);
        check("nomul_zso",   64'(zso0),           64'b011);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
